// File: rtl/tl_ul_arbiter_if.sv
// TileLink-UL signal bundle for the N-to-1 arbiter: per-master A/D channels packed by master index
// plus the single shared slave-side link.
interface tl_ul_arbiter_if #(
    parameter int N = 2,
    parameter int W = 4,
    parameter int A = 32,
    parameter int Z = 32,
    parameter int O = 1
);
    logic [N-1:0]       m_a_valid_i;
    logic [3*N-1:0]     m_a_opcode_i;
    logic [A*N-1:0]     m_a_address_i;
    logic [Z*N-1:0]     m_a_size_i;
    logic [W*N-1:0]     m_a_mask_i;
    logic [8*W*N-1:0]   m_a_data_i;
    logic [N-1:0]       m_a_ready_o;
    logic [N-1:0]       m_d_valid_o;
    logic [2:0]         m_d_opcode_o;
    logic [8*W-1:0]     m_d_data_o;
    logic               m_d_error_o;
    logic [N-1:0]       m_d_ready_i;

    logic               s_a_valid_o;
    logic [2:0]         s_a_opcode_o;
    logic [A-1:0]       s_a_address_o;
    logic [Z-1:0]       s_a_size_o;
    logic [W-1:0]       s_a_mask_o;
    logic [8*W-1:0]     s_a_data_o;
    logic [O-1:0]       s_a_source_o;
    logic               s_a_ready_i;
    logic               s_d_valid_i;
    logic [2:0]         s_d_opcode_i;
    logic [8*W-1:0]     s_d_data_i;
    logic               s_d_error_i;
    logic               s_d_ready_o;

    // The arbiter masters the shared link; the environment (requesters and memory) uses the slave view.
    modport master (
        input  m_a_valid_i, m_a_opcode_i, m_a_address_i, m_a_size_i, m_a_mask_i, m_a_data_i,
        output m_a_ready_o, m_d_valid_o, m_d_opcode_o, m_d_data_o, m_d_error_o,
        input  m_d_ready_i,
        output s_a_valid_o, s_a_opcode_o, s_a_address_o, s_a_size_o, s_a_mask_o, s_a_data_o,
        output s_a_source_o,
        input  s_a_ready_i, s_d_valid_i, s_d_opcode_i, s_d_data_i, s_d_error_i,
        output s_d_ready_o
    );

    modport slave (
        output m_a_valid_i, m_a_opcode_i, m_a_address_i, m_a_size_i, m_a_mask_i, m_a_data_i,
        input  m_a_ready_o, m_d_valid_o, m_d_opcode_o, m_d_data_o, m_d_error_o,
        output m_d_ready_i,
        input  s_a_valid_o, s_a_opcode_o, s_a_address_o, s_a_size_o, s_a_mask_o, s_a_data_o,
        input  s_a_source_o,
        output s_a_ready_i, s_d_valid_i, s_d_opcode_i, s_d_data_i, s_d_error_i,
        input  s_d_ready_o
    );
endinterface

// File: rtl/tl_ul_arbiter.sv
// Round-robin N-master to 1-slave TileLink-UL arbiter; one transaction in flight, grant held
// from A acceptance until the matching D beat is delivered.
module tl_ul_arbiter #(
    parameter int N = 2,
    parameter int W = 4,
    parameter int A = 32,
    parameter int Z = 32,
    parameter int O = 1
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    tl_ul_arbiter_if.master      bus,
    output logic                 busy_o,
    output logic [$clog2(N)-1:0] grant_o
);
    localparam int GW = $clog2(N);

    typedef enum logic [1:0] {IDLE, A_REQ, D_WAIT} state_t;

    state_t          state, next_state;
    logic [GW-1:0]   rr_ptr, grant_q, winner, idx;
    logic            found, d_fire;
    logic [2:0]      opcode_q;
    logic [A-1:0]    address_q;
    logic [Z-1:0]    size_q;
    logic [W-1:0]    mask_q;
    logic [8*W-1:0]  data_q;
    logic [O-1:0]    source_q;

    // Search starts one past the last completed grant so every requester is served within N turns.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 1; k <= N; k++) begin
            idx = GW'((int'(rr_ptr) + k) % N);
            if (!found && bus.m_a_valid_i[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign d_fire = (state == D_WAIT) && bus.s_d_valid_i && bus.m_d_ready_i[grant_q];

    always_ff @(posedge clk_i) begin
        if (reset_i) state <= IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (found)           next_state = A_REQ;
            A_REQ:   if (bus.s_a_ready_i) next_state = D_WAIT;
            D_WAIT:  if (d_fire)          next_state = IDLE;
            default:                      next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rr_ptr    <= GW'(N - 1);
            grant_q   <= '0;
            opcode_q  <= '0;
            address_q <= '0;
            size_q    <= '0;
            mask_q    <= '0;
            data_q    <= '0;
            source_q  <= '0;
        end else begin
            if (state == IDLE && found) begin
                grant_q   <= winner;
                opcode_q  <= bus.m_a_opcode_i[int'(winner)*3 +: 3];
                address_q <= bus.m_a_address_i[int'(winner)*A +: A];
                size_q    <= bus.m_a_size_i[int'(winner)*Z +: Z];
                mask_q    <= bus.m_a_mask_i[int'(winner)*W +: W];
                data_q    <= bus.m_a_data_i[int'(winner)*8*W +: 8*W];
                source_q  <= O'(winner);
            end
            if (d_fire) rr_ptr <= grant_q;
        end
    end

    // A-side acceptance is suppressed during reset because the payload registers cannot capture it.
    always_comb begin
        bus.m_a_ready_o  = '0;
        bus.m_d_valid_o  = '0;
        bus.m_d_opcode_o = '0;
        bus.m_d_data_o   = '0;
        bus.m_d_error_o  = 1'b0;
        bus.s_d_ready_o  = 1'b0;
        bus.s_a_valid_o  = 1'b0;
        unique case (state)
            IDLE:    if (found && !reset_i) bus.m_a_ready_o[winner] = 1'b1;
            A_REQ:   bus.s_a_valid_o = 1'b1;
            D_WAIT: begin
                bus.m_d_valid_o[grant_q] = bus.s_d_valid_i;
                bus.m_d_opcode_o         = bus.s_d_opcode_i;
                bus.m_d_data_o           = bus.s_d_data_i;
                bus.m_d_error_o          = bus.s_d_error_i;
                bus.s_d_ready_o          = bus.m_d_ready_i[grant_q];
            end
            default: ;
        endcase
    end

    assign bus.s_a_opcode_o  = opcode_q;
    assign bus.s_a_address_o = address_q;
    assign bus.s_a_size_o    = size_q;
    assign bus.s_a_mask_o    = mask_q;
    assign bus.s_a_data_o    = data_q;
    assign bus.s_a_source_o  = source_q;
    assign busy_o            = (state != IDLE);
    assign grant_o           = grant_q;
endmodule

// File: tb/tb_tl_ul_arbiter.sv
// Bench for tl_ul_arbiter: directed scenarios then random transactions, checked against a
// transaction-level round-robin model.
module tb_tl_ul_arbiter;
    localparam int N  = 3;
    localparam int W  = 4;
    localparam int A  = 32;
    localparam int Z  = 32;
    localparam int O  = 2;
    localparam int GW = $clog2(N);

    logic          clk_i;
    logic          reset_i;
    logic          busy_o;
    logic [GW-1:0] grant_o;

    tl_ul_arbiter_if #(.N(N), .W(W), .A(A), .Z(Z), .O(O)) bus ();

    tl_ul_arbiter #(.N(N), .W(W), .A(A), .Z(Z), .O(O)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus),
        .busy_o  (busy_o),
        .grant_o (grant_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;
    int last_grant;

    logic [N-1:0]   req_valid;
    logic [2:0]     req_op   [N];
    logic [A-1:0]   req_addr [N];
    logic [Z-1:0]   req_size [N];
    logic [W-1:0]   req_mask [N];
    logic [8*W-1:0] req_data [N];

    task automatic applyStimulus();
        for (int i = 0; i < N; i++) begin
            bus.m_a_opcode_i[3*i +: 3]       = req_op[i];
            bus.m_a_address_i[A*i +: A]      = req_addr[i];
            bus.m_a_size_i[Z*i +: Z]         = req_size[i];
            bus.m_a_mask_i[W*i +: W]         = req_mask[i];
            bus.m_a_data_i[8*W*i +: 8*W]     = req_data[i];
        end
        bus.m_a_valid_i = req_valid;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Winner is the requester at the smallest cyclic distance after the last completed grant.
    function automatic int model_winner(input logic [N-1:0] reqs);
        int best = -1;
        int best_dist = N;
        for (int i = 0; i < N; i++) begin
            if (reqs[i]) begin
                int d = (i - last_grant - 1 + 2*N) % N;
                if (d < best_dist) begin
                    best_dist = d;
                    best = i;
                end
            end
        end
        return best;
    endfunction

    task automatic randomize_new(input logic [N-1:0] reqs);
        for (int i = 0; i < N; i++) begin
            if (reqs[i] && !req_valid[i]) begin
                case ($urandom_range(0, 2))
                    0:       req_op[i] = 3'd4;
                    1:       req_op[i] = 3'd0;
                    default: req_op[i] = 3'd1;
                endcase
                req_addr[i] = A'($urandom);
                req_size[i] = Z'($urandom_range(0, 2));
                req_mask[i] = W'($urandom);
                req_data[i] = (8*W)'($urandom);
            end
        end
    endtask

    task automatic run_txn(input logic [N-1:0] reqs, input int a_stall, input int d_delay,
                           input int d_stall, input logic [2:0] d_op, input logic [8*W-1:0] d_data,
                           input logic d_err);
        int w;
        logic [N-1:0] oh;
        req_valid = reqs;
        applyStimulus();
        #1;
        w = model_winner(req_valid);
        oh = '0;
        oh[w] = 1'b1;
        checkOutput("a_ready_grant", bus.m_a_ready_o, oh);
        checkOutput("idle_busy", busy_o, 0);
        tick();
        req_valid[w] = 1'b0;
        applyStimulus();
        bus.s_a_ready_i = 1'b0;
        for (int c = 0; c <= a_stall; c++) begin
            if (c > 0) tick();
            bus.s_d_valid_i = 1'($urandom_range(0, 1));
            bus.m_d_ready_i = N'($urandom);
            #1;
            checkOutput("s_a_valid", bus.s_a_valid_o, 1);
            checkOutput("a_ready_held", bus.m_a_ready_o, 0);
            checkOutput("a_req_busy", busy_o, 1);
            checkOutput("s_a_opcode", bus.s_a_opcode_o, req_op[w]);
            checkOutput("s_a_address", bus.s_a_address_o, req_addr[w]);
            checkOutput("s_a_size", bus.s_a_size_o, req_size[w]);
            checkOutput("s_a_mask", bus.s_a_mask_o, req_mask[w]);
            checkOutput("s_a_data", bus.s_a_data_o, req_data[w]);
            checkOutput("s_a_source", bus.s_a_source_o, w);
            checkOutput("grant", grant_o, w);
            checkOutput("d_ignored_a_req", {bus.m_d_valid_o, bus.s_d_ready_o}, 0);
        end
        bus.s_a_ready_i = 1'b1;
        tick();
        bus.s_a_ready_i = 1'b0;
        bus.s_d_valid_i = 1'b0;
        bus.m_d_ready_i = '0;
        #1;
        checkOutput("s_a_valid_drop", bus.s_a_valid_o, 0);
        checkOutput("d_wait_busy", busy_o, 1);
        repeat (d_delay) begin
            checkOutput("d_quiet", bus.m_d_valid_o, 0);
            tick();
            #1;
        end
        bus.s_d_valid_i  = 1'b1;
        bus.s_d_opcode_i = d_op;
        bus.s_d_data_i   = d_data;
        bus.s_d_error_i  = d_err;
        for (int c = 0; c <= d_stall; c++) begin
            if (c == d_stall) bus.m_d_ready_i = N'($urandom) | oh;
            else              bus.m_d_ready_i = N'($urandom) & ~oh;
            #1;
            checkOutput("m_d_valid", bus.m_d_valid_o, oh);
            checkOutput("s_d_ready", bus.s_d_ready_o, (c == d_stall));
            checkOutput("m_d_opcode", bus.m_d_opcode_o, d_op);
            checkOutput("m_d_data", bus.m_d_data_o, d_data);
            checkOutput("m_d_error", bus.m_d_error_o, d_err);
            checkOutput("d_stall_busy", busy_o, 1);
            tick();
        end
        bus.s_d_valid_i = 1'b0;
        bus.m_d_ready_i = '0;
        #1;
        checkOutput("done_busy", busy_o, 0);
        checkOutput("done_grant", grant_o, w);
        last_grant = w;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int exp_seq [4];
        int busy_before;
        logic [N-1:0] reqs;
        exp_seq = '{1, 0, 1, 0};

        reset_i = 1'b1;
        req_valid = '0;
        for (int i = 0; i < N; i++) begin
            req_op[i] = 3'd4; req_addr[i] = '0; req_size[i] = '0; req_mask[i] = '0; req_data[i] = '0;
        end
        applyStimulus();
        bus.s_a_ready_i = 1'b0;
        bus.s_d_valid_i = 1'b0;
        bus.s_d_opcode_i = '0;
        bus.s_d_data_i = '0;
        bus.s_d_error_i = 1'b0;
        bus.m_d_ready_i = '0;
        repeat (2) tick();
        #1;
        checkOutput("rst_busy", busy_o, 0);
        checkOutput("rst_s_a_valid", bus.s_a_valid_o, 0);
        checkOutput("rst_grant", grant_o, 0);
        checkOutput("rst_s_a_address", bus.s_a_address_o, 0);
        checkOutput("rst_s_a_source", bus.s_a_source_o, 0);
        checkOutput("rst_m_a_ready", bus.m_a_ready_o, 0);
        checkOutput("rst_d_side", {bus.m_d_valid_o, bus.s_d_ready_o}, 0);
        reset_i = 1'b0;
        last_grant = N - 1;

        $display("[TB] single Get from m0");
        req_op[0] = 3'd4; req_addr[0] = 32'h100; req_size[0] = 32'd2; req_mask[0] = 4'hF; req_data[0] = '0;
        run_txn(3'b001, 0, 1, 0, 3'd1, 32'hDEADBEEF, 1'b0);

        $display("[TB] m0 and m1 requesting continuously");
        for (int k = 0; k < 4; k++) begin
            randomize_new(3'b011);
            run_txn(3'b011, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 1),
                    3'($urandom_range(0, 1)), (8*W)'($urandom), 1'b0);
            checkOutput("alternating_grant", grant_o, exp_seq[k]);
        end

        $display("[TB] slave A stall of 5 cycles");
        run_txn(req_valid, 5, 0, 0, 3'd0, '0, 1'b0);

        $display("[TB] D stall and error forwarding on PutPartial");
        req_op[1] = 3'd1; req_addr[1] = 32'h2000; req_size[1] = 32'd1; req_mask[1] = 4'h3; req_data[1] = 32'h0000BEEF;
        run_txn(3'b010, 0, 1, 3, 3'd0, (8*W)'($urandom), 1'b1);

        $display("[TB] reset during A_REQ");
        randomize_new(3'b100);
        req_valid = 3'b100;
        applyStimulus();
        tick();
        req_valid = '0;
        applyStimulus();
        #1;
        busy_before = int'(busy_o);
        checkOutput("pre_reset_a_req", busy_before, 1);
        reset_i = 1'b1;
        tick();
        #1;
        checkOutput("rst_a_req_busy", busy_o, 0);
        checkOutput("rst_a_req_s_a_valid", bus.s_a_valid_o, 0);
        checkOutput("rst_a_req_m_d_valid", bus.m_d_valid_o, 0);
        reset_i = 1'b0;
        last_grant = N - 1;

        $display("[TB] reset during D_WAIT");
        req_valid = 3'b100;
        applyStimulus();
        tick();
        req_valid = '0;
        applyStimulus();
        bus.s_a_ready_i = 1'b1;
        tick();
        bus.s_a_ready_i = 1'b0;
        bus.s_d_valid_i = 1'b1;
        bus.m_d_ready_i = '0;
        #1;
        checkOutput("pre_reset_d_valid", bus.m_d_valid_o, 3'b100);
        reset_i = 1'b1;
        tick();
        #1;
        checkOutput("rst_d_wait_busy", busy_o, 0);
        checkOutput("rst_d_wait_s_a_valid", bus.s_a_valid_o, 0);
        checkOutput("rst_d_wait_m_d_valid", bus.m_d_valid_o, 0);
        checkOutput("rst_d_wait_s_d_ready", bus.s_d_ready_o, 0);
        reset_i = 1'b0;
        bus.s_d_valid_i = 1'b0;
        last_grant = N - 1;
        randomize_new(3'b111);
        run_txn(3'b111, 0, 0, 0, 3'd1, (8*W)'($urandom), 1'b0);
        checkOutput("post_reset_first_grant", grant_o, 0);

        $display("[TB] random transactions");
        for (int t = 0; t < 40; t++) begin
            reqs = N'($urandom_range(0, (1 << N) - 1)) | req_valid;
            if (reqs == '0) begin
                applyStimulus();
                #1;
                checkOutput("idle_no_ready", bus.m_a_ready_o, 0);
                checkOutput("idle_no_busy", busy_o, 0);
                tick();
            end else begin
                randomize_new(reqs);
                run_txn(reqs, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                        3'($urandom_range(0, 1)), (8*W)'($urandom), 1'($urandom_range(0, 1)));
            end
        end

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
